// File: rtl/branch_hazard_ctrl_if.sv
// Branch hazard bundle between the ID stage and the branch hazard controller.
// The ID-stage driver is the master; the hazard controller is the slave.
interface branch_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int BRANCH_W   = 2,
    parameter int CNT_W      = 16
);
    logic                  hold;
    logic [BRANCH_W-1:0]   id_branch;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  id_valid;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  stall;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output hold, id_branch, id_rs, id_rt, id_rd, id_reg_write, id_mem_read, id_valid,
        input  fwd_a, fwd_b, stall, stall_cycles
    );

    modport slave (
        input  hold, id_branch, id_rs, id_rt, id_rd, id_reg_write, id_mem_read, id_valid,
        output fwd_a, fwd_b, stall, stall_cycles
    );
endinterface

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard controller. Shadows the EX/MEM/WB register writers,
// resolves per-operand forwarding for branches evaluated in ID, requests stalls
// when a producer result is not yet reachable, and counts stall cycles.
module branch_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int BRANCH_W   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    branch_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic                  v;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
        logic                  ld;
    } slot_t;

    localparam slot_t BUBBLE = '{v: 1'b0, rd: {REG_ADDR_W{1'b0}}, wr: 1'b0, ld: 1'b0};

    slot_t            ex_r;
    slot_t            mem_r;
    slot_t            wb_r;
    logic [CNT_W-1:0] cnt_r;

    logic [1:0]       fwd_a_s;
    logic [1:0]       fwd_b_s;
    logic             stall_s;
    logic [2:0]       res_a_s;
    logic [2:0]       res_b_s;

    // A slot produces a value for src only if it is a real writer of a non-zero register.
    function automatic logic writes_src(input slot_t s, input logic [REG_ADDR_W-1:0] src);
        return s.v && s.wr && (s.rd != {REG_ADDR_W{1'b0}}) && (s.rd == src);
    endfunction

    // Returns {stall, fwd[1:0]} for one branch operand.
    function automatic logic [2:0] resolve(input logic [REG_ADDR_W-1:0] src,
                                           input slot_t ex, input slot_t mem, input slot_t wb);
        logic       stl;
        logic [1:0] fwd;
        // EX results (ALU or load) cannot reach ID yet; a load in MEM is also too late.
        stl = writes_src(ex, src) || (writes_src(mem, src) && mem.ld);
        if (writes_src(mem, src) && !mem.ld) begin
            fwd = 2'b10;
        end else if (writes_src(wb, src)) begin
            fwd = 2'b01;
        end else begin
            fwd = 2'b00;
        end
        return {stl, fwd};
    endfunction

    // Hazard evaluation for a valid branch in ID; everything else sees no hazard.
    always_comb begin
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        stall_s = 1'b0;
        res_a_s = resolve(bus.id_rs, ex_r, mem_r, wb_r);
        res_b_s = resolve(bus.id_rt, ex_r, mem_r, wb_r);
        if (bus.id_valid && (bus.id_branch != {BRANCH_W{1'b0}})) begin
            fwd_a_s = res_a_s[1:0];
            fwd_b_s = res_b_s[1:0];
            stall_s = res_a_s[2] | res_b_s[2];
        end else begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
            stall_s = 1'b0;
        end
    end

    // Shadow pipeline advance and saturating stall counter; reset overrides hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_r  <= BUBBLE;
            mem_r <= BUBBLE;
            wb_r  <= BUBBLE;
            cnt_r <= {CNT_W{1'b0}};
        end else if (!bus.hold) begin
            wb_r  <= mem_r;
            mem_r <= ex_r;
            if (stall_s) begin
                ex_r <= BUBBLE;
            end else begin
                ex_r <= '{v: bus.id_valid, rd: bus.id_rd, wr: bus.id_reg_write, ld: bus.id_mem_read};
            end
            if (stall_s && (cnt_r != {CNT_W{1'b1}})) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end else begin
            ex_r  <= ex_r;
            mem_r <= mem_r;
            wb_r  <= wb_r;
            cnt_r <= cnt_r;
        end
    end

    assign bus.fwd_a        = fwd_a_s;
    assign bus.fwd_b        = fwd_b_s;
    assign bus.stall        = stall_s;
    assign bus.stall_cycles = cnt_r;
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: a default-width instance plus a
// CNT_W=2 instance sharing the same stimulus for the saturation check.
module tb_branch_hazard_ctrl;
    logic clk;
    logic reset;
    int   vecs;
    int   errs;

    branch_hazard_ctrl_if #(.REG_ADDR_W(5), .BRANCH_W(2), .CNT_W(16)) bus ();
    branch_hazard_ctrl_if #(.REG_ADDR_W(5), .BRANCH_W(2), .CNT_W(2))  bus2 ();

    branch_hazard_ctrl #(.REG_ADDR_W(5), .BRANCH_W(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));
    branch_hazard_ctrl #(.REG_ADDR_W(5), .BRANCH_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));

    assign bus2.hold         = bus.hold;
    assign bus2.id_branch    = bus.id_branch;
    assign bus2.id_rs        = bus.id_rs;
    assign bus2.id_rt        = bus.id_rt;
    assign bus2.id_rd        = bus.id_rd;
    assign bus2.id_reg_write = bus.id_reg_write;
    assign bus2.id_mem_read  = bus.id_mem_read;
    assign bus2.id_valid     = bus.id_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic s, input logic [1:0] fa, input logic [1:0] fb);
        chk({tag, ".stall"}, {31'd0, bus.stall}, {31'd0, s});
        chk({tag, ".fwd_a"}, {30'd0, bus.fwd_a}, {30'd0, fa});
        chk({tag, ".fwd_b"}, {30'd0, bus.fwd_b}, {30'd0, fb});
    endtask

    task automatic drv(input logic v, input logic [1:0] br, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic rw, input logic mr);
        bus.id_valid     = v;
        bus.id_branch    = br;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        bus.hold = 1'b0;
        drv(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        reset = 1'b1;
        bus.hold = 1'b0;
        drv(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk3("reset", 1'b0, 2'b00, 2'b00);
        chk("reset.cnt", {16'd0, bus.stall_cycles}, 32'd0);
        chk("reset.cnt2", {30'd0, bus2.stall_cycles}, 32'd0);
        reset = 1'b0;

        // ALU producer directly ahead of the branch
        drv(1'b1, 2'b00, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);      // add r1
        chk("alu.add.stall", {31'd0, bus.stall}, 32'd0);
        tick();
        drv(1'b1, 2'b01, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);      // beq r1,r2
        chk3("alu.c1", 1'b1, 2'b00, 2'b00);
        tick();
        chk3("alu.c2", 1'b0, 2'b10, 2'b00);
        chk("alu.cnt", {16'd0, bus.stall_cycles}, 32'd1);

        // Load directly ahead of the branch
        do_reset();
        drv(1'b1, 2'b00, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);      // lw r3
        tick();
        drv(1'b1, 2'b01, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0);      // beq r2,r3
        chk("ld.c1.stall", {31'd0, bus.stall}, 32'd1);
        tick();
        chk("ld.c2.stall", {31'd0, bus.stall}, 32'd1);
        chk("ld.c2.cnt", {16'd0, bus.stall_cycles}, 32'd1);
        tick();
        chk3("ld.c3", 1'b0, 2'b00, 2'b01);
        chk("ld.cnt", {16'd0, bus.stall_cycles}, 32'd2);

        // Independent dual forward: r5 from MEM, r4 from WB
        do_reset();
        drv(1'b1, 2'b00, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);      // add r4
        tick();
        drv(1'b1, 2'b00, 5'd4, 5'd4, 5'd5, 1'b1, 1'b0);      // add r5 (not a branch)
        chk("dual.nonbr.stall", {31'd0, bus.stall}, 32'd0);
        tick();
        drv(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);      // nop
        tick();
        drv(1'b1, 2'b10, 5'd5, 5'd4, 5'd0, 1'b0, 1'b0);      // beq r5,r4
        chk3("dual", 1'b0, 2'b10, 2'b01);

        // Load two instructions ahead: one stall then WB forward
        do_reset();
        drv(1'b1, 2'b00, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);      // lw r3
        tick();
        drv(1'b1, 2'b00, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);      // add r9
        tick();
        drv(1'b1, 2'b01, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0);      // beq r3,r0
        chk("ld2.c1.stall", {31'd0, bus.stall}, 32'd1);
        tick();
        chk3("ld2.c2", 1'b0, 2'b01, 2'b00);

        // Register zero is never a hazard
        do_reset();
        drv(1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);      // add r0
        tick();
        drv(1'b1, 2'b01, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);      // beq r0,r0
        chk3("r0.c1", 1'b0, 2'b00, 2'b00);
        tick();
        chk3("r0.c2", 1'b0, 2'b00, 2'b00);

        // Non-branch and invalid-ID filtering against a live EX writer
        do_reset();
        drv(1'b1, 2'b00, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);      // add r7
        tick();
        drv(1'b0, 2'b01, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);      // bubble carrying branch bits
        chk3("filt.invalid", 1'b0, 2'b00, 2'b00);
        drv(1'b1, 2'b00, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);      // id_branch=00
        chk3("filt.nobranch", 1'b0, 2'b00, 2'b00);

        // Same register on both operands
        do_reset();
        drv(1'b1, 2'b00, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0);      // add r6
        tick();
        drv(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);      // nop
        tick();
        drv(1'b1, 2'b11, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);      // beq r6,r6
        chk3("same", 1'b0, 2'b10, 2'b10);

        // Hold freezes stall, slots and counter
        do_reset();
        drv(1'b1, 2'b00, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);      // add r1
        tick();
        bus.hold = 1'b1;
        drv(1'b1, 2'b01, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);      // beq r1,r2
        for (int i = 0; i < 3; i++) begin
            chk("hold.stall", {31'd0, bus.stall}, 32'd1);
            chk("hold.cnt", {16'd0, bus.stall_cycles}, 32'd0);
            tick();
        end
        bus.hold = 1'b0;
        #1;
        chk("hold.rel.stall", {31'd0, bus.stall}, 32'd1);
        tick();
        chk3("hold.after", 1'b0, 2'b10, 2'b00);
        chk("hold.cnt.after", {16'd0, bus.stall_cycles}, 32'd1);

        // Reset (with hold) during a load stall
        do_reset();
        drv(1'b1, 2'b00, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1);      // lw r3
        tick();
        drv(1'b1, 2'b01, 5'd2, 5'd3, 5'd0, 1'b0, 1'b0);      // beq r2,r3
        tick();
        chk("rst.pre.stall", {31'd0, bus.stall}, 32'd1);
        chk("rst.pre.cnt", {16'd0, bus.stall_cycles}, 32'd1);
        reset    = 1'b1;
        bus.hold = 1'b1;
        tick();
        reset    = 1'b0;
        bus.hold = 1'b0;
        #1;
        chk3("rst.post", 1'b0, 2'b00, 2'b00);
        chk("rst.post.cnt", {16'd0, bus.stall_cycles}, 32'd0);

        // Five single-cycle ALU stalls: 16-bit counter reads 5, 2-bit counter saturates at 3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(1'b1, 2'b00, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);  // add r1
            tick();
            drv(1'b1, 2'b01, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);  // beq r1,r2
            tick();
            tick();
        end
        chk("sat.cnt16", {16'd0, bus.stall_cycles}, 32'd5);
        chk("sat.cnt2", {30'd0, bus2.stall_cycles}, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
